key_debounce: RTL



---
 rtl/key_debounce_pkg.sv | 12 +
 rtl/key_debounce_channel.sv | 86 ++++++++
 rtl/key_debounce.sv | 31 +++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared defaults and key state encoding for the key debouncer
package key_debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_REPEAT_CYCLES   = 25000000;

    typedef enum logic {
        KEY_PRESSED  = 1'b0,
        KEY_RELEASED = 1'b1
    } key_state_t;

endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one key: 2-flop synchroniser, stability counter, level and edge pulses (auto-repeat under KEY_DEBOUNCE_REPEAT_EN)
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic key_n,
    output logic level_n,
    output logic key_press,
    output logic key_release
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_debounce_channel: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("key_debounce_channel: REPEAT_CYCLES must be >= 2");
    end

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    key_state_t    level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          differ;
    logic          accept;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int            RW      = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rpt_q, rpt_d;
    logic          rpt_fire;
`endif

    // accept a new level only after the synchronised input has disagreed for DEBOUNCE_CYCLES edges in a row
    always_comb begin
        differ    = sync2_q != level_q;
        accept    = differ && (cnt_q == CNT_MAX);
        cnt_d     = (differ && !accept) ? cnt_q + 1'b1 : '0;
        level_d   = accept ? key_state_t'(sync2_q) : level_q;
        release_d = accept && (level_q == KEY_PRESSED);
`ifdef KEY_DEBOUNCE_REPEAT_EN
        rpt_fire  = !accept && (level_q == KEY_PRESSED) && (rpt_q == RPT_MAX);
        rpt_d     = (accept || level_q == KEY_RELEASED || rpt_fire) ? '0 : rpt_q + 1'b1;
        press_d   = (accept && (level_q == KEY_RELEASED)) || rpt_fire;
`else
        press_d   = accept && (level_q == KEY_RELEASED);
`endif
    end

    // all state resets to the released condition so no pulse survives an aborted count
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            level_q   <= KEY_RELEASED;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            rpt_q     <= '0;
`endif
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            rpt_q     <= rpt_d;
`endif
        end
    end

    assign level_n     = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: synchronise and debounce NUM_KEYS active-low keys into clean levels plus press/release pulses (auto-repeat under KEY_DEBOUNCE_REPEAT_EN)
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [NUM_KEYS-1:0] Key_n,
    output logic [NUM_KEYS-1:0] Key_level_n,
    output logic [NUM_KEYS-1:0] Key_press,
    output logic [NUM_KEYS-1:0] Key_release
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_chan (
            .Clk        (Clk),
            .Reset_n    (Reset_n),
            .key_n      (Key_n[i]),
            .level_n    (Key_level_n[i]),
            .key_press  (Key_press[i]),
            .key_release(Key_release[i])
        );
    end

endmodule
